apb_master: RTL and testbench
=============================

# apb_master

Single-channel AMBA APB requester that sits directly upstream of the team's APB memory slave. It accepts one read or write command at a time on a valid/ready command port, runs the APB SETUP → ACCESS protocol (P_selx, P_enable, P_write, P_addr, P_wdata), waits for P_ready, and returns P_rdata/P_slverr on a valid/ready response port. An optional timeout aborts transfers whose slave never asserts P_ready.

## Interface
- ADDR_W, 32, width of cmd_addr and P_addr
- DATA_W, 32, width of write/read data buses
- TIMEOUT, 16, ACCESS-phase wait limit in cycles; used only with APB_MASTER_TIMEOUT_EN; legal range 1..255

Ports:
- P_clk  input  1  single clock, all state updates on its rising edge
- P_rst_n  input  1  asynchronous, active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  block can accept a command
- cmd_write  input  1  1 = write, 0 = read
- cmd_addr  input  ADDR_W  transfer address
- cmd_wdata  input  DATA_W  write data (ignored on reads)
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer accepts response
- rsp_rdata  output  DATA_W  read data (0 for writes)
- rsp_slverr  output  1  slave error or timeout
- P_selx  output  1  APB select
- P_enable  output  1  APB enable
- P_write  output  1  APB direction
- P_addr  output  ADDR_W  APB address
- P_wdata  output  DATA_W  APB write data
- P_ready  input  1  slave ready
- P_slverr  input  1  slave error
- P_rdata  input  DATA_W  slave read data

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP; all outputs are driven from registers, except cmd_ready, which equals (state == IDLE).
- IDLE: on cmd_valid && cmd_ready, latch cmd_write, cmd_addr, cmd_wdata into P_write, P_addr, P_wdata (P_wdata = 0 on reads), set P_selx = 1, and go to SETUP.
- SETUP: P_selx = 1, P_enable = 0. Unconditionally set P_enable = 1 and go to ACCESS.
- ACCESS: P_selx = 1, P_enable = 1. P_ready, P_rdata, and P_slverr are sampled only in this state.
  - If P_ready = 1: capture rsp_rdata = (read ? P_rdata : 0), rsp_slverr = P_slverr, clear P_selx and P_enable, set rsp_valid = 1, and go to RESP.
  - If P_ready = 0: stay in ACCESS.
- RESP: hold rsp_valid, rsp_rdata, and rsp_slverr stable. On rsp_ready = 1, clear rsp_valid and go to IDLE.
- P_addr, P_write, and P_wdata are stable from SETUP through the last ACCESS cycle, and hold their last values in IDLE/RESP.
- Only one transfer is outstanding at a time; no command is accepted while in SETUP, ACCESS, or RESP.
- P_ready or P_slverr asserted outside ACCESS is ignored.

## Timing
- Reset (P_rst_n = 0, asynchronous) forces state IDLE and clears all outputs immediately: P_selx = 0, P_enable = 0, P_write = 0, P_addr = 0, P_wdata = 0, rsp_valid = 0, rsp_rdata = 0, rsp_slverr = 0, and the timeout counter = 0. cmd_ready = 1 in the first cycle after reset release.
- Reset mid-transfer drops P_selx and P_enable without completion; no response is produced.
- Latency from command handshake edge:
  - P_selx rises at +1 (SETUP).
  - P_enable rises at +2 (ACCESS).
  - With a zero-wait slave (P_ready = 1 in the first ACCESS cycle), rsp_valid rises at +3.
  - Each wait cycle adds 1.
- Minimum 4 cycles per transfer (IDLE, SETUP, ACCESS, RESP), assuming rsp_ready is held high.
- rsp_ready low stalls in RESP indefinitely; APB is idle (P_selx = 0) while stalled.

## Configuration
- Macro: APB_MASTER_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entering ACCESS and increments on each ACCESS cycle with P_ready = 0.
  - When the count reaches TIMEOUT with P_ready still 0, the transfer aborts: P_selx = P_enable = 0, rsp_slverr = 1, rsp_rdata = 0, go to RESP.
  - If P_ready = 1 arrives in the same cycle the count reaches TIMEOUT, P_ready wins and the normal response is used.
- Undefined: no counter and no TIMEOUT use; ACCESS waits for P_ready forever.

## Test plan
- Write, zero-wait: cmd write, addr 0x04, data 0xDEADBEEF, slave P_ready = 1 in the first ACCESS cycle -> P_selx at +1, P_enable at +2, rsp_valid at +3 with rsp_slverr = 0, rsp_rdata = 0.
- Read with 2 wait states: slave returns P_rdata = 0x0000000C and P_ready after 2 ACCESS cycles -> rsp_valid at +5, rsp_rdata = 0x0000000C; P_addr stable throughout.
- Slave error plus back-pressure: P_slverr = 1 with P_ready, rsp_ready held low for 3 cycles -> rsp_slverr = 1 and rsp_valid held for 3 cycles, cmd_ready = 0 until the rsp handshake, P_selx = 0 while stalled.
- Reset mid-ACCESS: assert P_rst_n = 0 while P_enable = 1 -> P_selx, P_enable, and rsp_valid go to 0 immediately (asynchronously); cmd_ready = 1 in the first cycle after release.
- Timeout (macro defined, TIMEOUT = 4): slave never asserts P_ready -> after 4 wait cycles, rsp_valid = 1, rsp_slverr = 1, rsp_rdata = 0. Macro undefined: rsp_valid stays 0 for 100 cycles.

Source files
------------

// File: rtl/apb_master.sv
// apb_master: single-channel AMBA APB requester.
//
// Accepts one read/write command at a time on a valid/ready command port,
// runs the APB SETUP -> ACCESS sequence, waits for P_ready and returns the
// read data / error flag on a valid/ready response port.
//
// Optional feature macro: APB_MASTER_TIMEOUT_EN
//   When defined, an 8-bit wait counter aborts an ACCESS phase whose slave
//   never asserts P_ready. The abort happens on the TIMEOUT-th consecutive
//   not-ready ACCESS cycle. It reports rsp_slverr = 1 and rsp_rdata = 0.
//   When undefined, ACCESS waits for P_ready indefinitely.
//
// Parameters:
//   ADDR_W   width of cmd_addr / P_addr
//   DATA_W   width of write and read data buses
//   TIMEOUT  ACCESS wait limit in cycles (1..255); used with the macro only
//
// Ports:
//   P_clk, P_rst_n            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready       command handshake (cmd_ready = state is IDLE)
//   cmd_write/addr/wdata      command payload
//   rsp_valid/rsp_ready       response handshake
//   rsp_rdata/rsp_slverr      response payload (rdata is 0 for writes)
//   P_selx/enable/write/      APB requester outputs, all registered
//   P_addr/P_wdata
//   P_ready/slverr/rdata      APB completer inputs, sampled in ACCESS only
module apb_master #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              P_clk,
  input  logic              P_rst_n,
  // command port
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  // response port
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_slverr,
  // APB requester side
  output logic              P_selx,
  output logic              P_enable,
  output logic              P_write,
  output logic [ADDR_W-1:0] P_addr,
  output logic [DATA_W-1:0] P_wdata,
  input  logic              P_ready,
  input  logic              P_slverr,
  input  logic [DATA_W-1:0] P_rdata
);

  // Reject an out-of-range wait limit at elaboration.
  if (TIMEOUT == 0 || TIMEOUT > 255) begin : g_timeout_range
    $error("apb_master: TIMEOUT must be in 1..255");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t state;

  // Only the IDLE state can take a new command.
  assign cmd_ready = (state == S_IDLE);

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int unsigned    CNT_W   = 8;
  // Count value on the cycle whose not-ready outcome would reach TIMEOUT.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] wait_cnt;
`endif

  // Transfer sequencer: state plus every registered output.
  always_ff @(posedge P_clk or negedge P_rst_n) begin
    if (!P_rst_n) begin
      state      <= S_IDLE;
      P_selx     <= 1'b0;
      P_enable   <= 1'b0;
      P_write    <= 1'b0;
      P_addr     <= '0;
      P_wdata    <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_slverr <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      wait_cnt   <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            // Address/control are latched once and held until the next command.
            P_write <= cmd_write;
            P_addr  <= cmd_addr;
            P_wdata <= cmd_write ? cmd_wdata : '0;
            P_selx  <= 1'b1;
            state   <= S_SETUP;
          end
        end

        S_SETUP: begin
          P_enable <= 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          state    <= S_ACCESS;
        end

        S_ACCESS: begin
          if (P_ready) begin
            // A ready slave takes priority over a simultaneous timeout.
            rsp_rdata  <= P_write ? '0 : P_rdata;
            rsp_slverr <= P_slverr;
            P_selx     <= 1'b0;
            P_enable   <= 1'b0;
            rsp_valid  <= 1'b1;
            state      <= S_RESP;
          end
`ifdef APB_MASTER_TIMEOUT_EN
          else if (wait_cnt == CNT_LAST) begin
            rsp_rdata  <= '0;
            rsp_slverr <= 1'b1;
            P_selx     <= 1'b0;
            P_enable   <= 1'b0;
            rsp_valid  <= 1'b1;
            state      <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
`endif
        end

        S_RESP: begin
          // APB bus is already idle; only the response handshake remains.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: randomized scoreboard bench for apb_master.
// A driver issues commands and pushes the expected response; an APB slave
// model answers with scripted wait states; a monitor pops and compares.
module tb_apb_master;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned TB_TIMEOUT = 16;

  logic              P_clk      = 1'b0;
  logic              P_rst_n    = 1'b0;
  logic              cmd_valid  = 1'b0;
  logic              cmd_ready;
  logic              cmd_write  = 1'b0;
  logic [ADDR_W-1:0] cmd_addr   = '0;
  logic [DATA_W-1:0] cmd_wdata  = '0;
  logic              rsp_valid;
  logic              rsp_ready  = 1'b0;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_slverr;
  logic              P_selx;
  logic              P_enable;
  logic              P_write;
  logic [ADDR_W-1:0] P_addr;
  logic [DATA_W-1:0] P_wdata;
  logic              P_ready    = 1'b0;
  logic              P_slverr   = 1'b0;
  logic [DATA_W-1:0] P_rdata    = '0;

  apb_master #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TB_TIMEOUT)
  ) dut (
    .P_clk     (P_clk),
    .P_rst_n   (P_rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_slverr(rsp_slverr),
    .P_selx    (P_selx),
    .P_enable  (P_enable),
    .P_write   (P_write),
    .P_addr    (P_addr),
    .P_wdata   (P_wdata),
    .P_ready   (P_ready),
    .P_slverr  (P_slverr),
    .P_rdata   (P_rdata)
  );

  always #5 P_clk = ~P_clk;

  int cyc = 0;
  always @(posedge P_clk) cyc++;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic        err;
    int          stall;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          push_cyc;
    int          exp_cyc;
  } txn_t;

  txn_t        sb_q[$];
  txn_t        sl_q[$];
  logic [31:0] ref_mem[16];
  logic [31:0] slave_mem[16];

  // Issue one command; expected response comes from the reference memory.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input int waits, input logic err, input int stall);
    txn_t t;
    int   guard;
    int   idx;
    logic timed_out;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    guard = 0;
    while (!cmd_ready && guard < 500) begin
      @(negedge P_clk);
      guard++;
    end
    if (!cmd_ready) begin
      chk("cmd_accept_timeout", 0, 1);
      cmd_valid = 1'b0;
      return;
    end
    idx = int'(a[5:2]);
    t.write = w;
    t.addr  = a;
    t.wdata = d;
    t.waits = waits;
    t.err   = err;
    t.stall = stall;
    t.push_cyc = cyc;
`ifdef APB_MASTER_TIMEOUT_EN
    timed_out = (waits >= int'(TB_TIMEOUT));
`else
    timed_out = 1'b0;
`endif
    if (timed_out) begin
      t.exp_rdata = 32'h0;
      t.exp_err   = 1'b1;
      t.exp_cyc   = cyc + 3 + int'(TB_TIMEOUT) - 1;
    end else begin
      t.exp_rdata = w ? 32'h0 : ref_mem[idx];
      t.exp_err   = err;
      t.exp_cyc   = cyc + 3 + waits;
      if (w && !err) ref_mem[idx] = d;
    end
    sb_q.push_back(t);
    sl_q.push_back(t);
    @(negedge P_clk);
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom);
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
  endtask

  // APB slave model: scripted wait states, memory-backed reads, noise when idle.
  txn_t sl_cur;
  bit   sl_active = 1'b0;
  int   sl_acc = 0;
  always @(negedge P_clk) begin
    if (!P_rst_n) begin
      sl_active = 1'b0;
      P_ready   = 1'b0;
      P_slverr  = 1'b0;
    end else if (P_selx && !P_enable) begin
      if (sl_q.size() == 0) begin
        chk("unexpected_setup", 1, 0);
      end else begin
        sl_cur    = sl_q.pop_front();
        sl_active = 1'b1;
        sl_acc    = 0;
        chk("selx_latency", 128'(cyc), 128'(sl_cur.push_cyc + 1));
        chk("setup_ctl", {P_write, P_addr, P_wdata},
            {sl_cur.write, sl_cur.addr, sl_cur.write ? sl_cur.wdata : 32'h0});
      end
      P_ready  = 1'($urandom);
      P_slverr = 1'($urandom);
      P_rdata  = $urandom;
    end else if (P_selx && P_enable) begin
      if (!sl_active) begin
        chk("access_overrun", 1, 0);
        P_ready = 1'b0;
      end else begin
        if (sl_acc == 0) chk("enable_latency", 128'(cyc), 128'(sl_cur.push_cyc + 2));
        chk("access_ctl", {P_write, P_addr, P_wdata},
            {sl_cur.write, sl_cur.addr, sl_cur.write ? sl_cur.wdata : 32'h0});
        if (sl_acc == sl_cur.waits) begin
          P_ready  = 1'b1;
          P_slverr = sl_cur.err;
          P_rdata  = sl_cur.write ? 32'($urandom) : slave_mem[int'(P_addr[5:2])];
          if (sl_cur.write && !sl_cur.err) slave_mem[int'(P_addr[5:2])] = P_wdata;
          sl_active = 1'b0;
        end else begin
          P_ready  = 1'b0;
          P_slverr = 1'($urandom);
          P_rdata  = $urandom;
          sl_acc++;
        end
      end
    end else begin
      sl_active = 1'b0;
      P_ready   = 1'($urandom);
      P_slverr  = 1'($urandom);
      P_rdata   = $urandom;
    end
  end

  // Response monitor: latency, stall behaviour and payload against the scoreboard.
  bit mon_busy = 1'b0;
  int mon_hold = 0;
  always @(negedge P_clk) begin
    if (!P_rst_n) begin
      mon_busy  = 1'b0;
      rsp_ready = 1'b0;
    end else if (rsp_valid) begin
      if (!mon_busy) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_rsp", 1, 0);
          rsp_ready = 1'b1;
        end else begin
          mon_busy = 1'b1;
          mon_hold = 0;
          chk("rsp_latency", 128'(cyc), 128'(sb_q[0].exp_cyc));
        end
      end
      chk("apb_idle_in_resp", {cmd_ready, P_selx, P_enable}, 0);
      if (mon_busy) begin
        if (mon_hold == sb_q[0].stall) begin
          rsp_ready = 1'b1;
          chk("rsp_rdata", rsp_rdata, sb_q[0].exp_rdata);
          chk("rsp_slverr", rsp_slverr, sb_q[0].exp_err);
          void'(sb_q.pop_front());
          mon_busy = 1'b0;
        end else begin
          rsp_ready = 1'b0;
          mon_hold++;
        end
      end
    end else begin
      if (mon_busy) begin
        chk("rsp_dropped", 0, 1);
        mon_busy = 1'b0;
      end
      rsp_ready = 1'($urandom);
    end
  end

  task automatic drain();
    int guard;
    guard = 0;
    while ((sb_q.size() != 0 || sl_q.size() != 0) && guard < 1000) begin
      @(negedge P_clk);
      guard++;
    end
    @(negedge P_clk);
    chk("drain", 128'(sb_q.size() + sl_q.size()), 0);
  endtask

  initial begin
    int   guard;
    int   busy_cycles;
    int   waits;
    logic [31:0] a;

    for (int i = 0; i < 16; i++) begin
      a = $urandom;
      ref_mem[i]   = a;
      slave_mem[i] = a;
    end

    // Reset state
    repeat (2) @(negedge P_clk);
    chk("reset_ctl", {cmd_ready, P_selx, P_enable, P_write, rsp_valid, rsp_slverr}, 6'b100000);
    chk("reset_addr", P_addr, 0);
    chk("reset_wdata", P_wdata, 0);
    chk("reset_rdata", rsp_rdata, 0);
    P_rst_n = 1'b1;
    @(negedge P_clk);
    chk("cmd_ready_after_reset", cmd_ready, 1);

    // Directed cases
    issue(1'b1, 32'h04, 32'hDEADBEEF, 0, 1'b0, 0);
    issue(1'b1, 32'h08, 32'h0000000C, 1, 1'b0, 0);
    issue(1'b0, 32'h08, 32'h0, 2, 1'b0, 0);
    issue(1'b1, 32'h10, 32'h12345678, 0, 1'b1, 3);
    issue(1'b0, 32'h04, 32'h0, 0, 1'b0, 0);
    issue(1'b0, 32'h10, 32'h0, 1, 1'b1, 2);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
`ifdef APB_MASTER_TIMEOUT_EN
      if ($urandom_range(0, 9) == 0)
        waits = int'(TB_TIMEOUT) - 1 + int'($urandom_range(0, 2));
      else
        waits = int'($urandom_range(0, 5));
`else
      waits = int'($urandom_range(0, 5));
`endif
      a = 32'($urandom_range(0, 15)) << 2;
      issue(1'($urandom), a, $urandom, waits, ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
      repeat ($urandom_range(0, 2)) @(negedge P_clk);
    end
    drain();

    // Stuck slave, then reset in the middle of ACCESS
    issue(1'b0, 32'h0C, 32'h0, 1000000, 1'b0, 0);
    guard = 0;
    while (!P_enable && guard < 20) begin
      @(negedge P_clk);
      guard++;
    end
    chk("stuck_access_reached", P_enable, 1);
`ifdef APB_MASTER_TIMEOUT_EN
    repeat (2) @(negedge P_clk);
`else
    busy_cycles = 0;
    repeat (100) begin
      @(negedge P_clk);
      if (rsp_valid) busy_cycles++;
    end
    chk("no_rsp_while_stuck", 128'(busy_cycles), 0);
`endif
    #2;
    P_rst_n = 1'b0;
    #1;
    chk("async_reset_mid_access", {P_selx, P_enable, rsp_valid}, 3'b000);
    sb_q.delete();
    sl_q.delete();
    repeat (2) @(negedge P_clk);
    P_rst_n = 1'b1;
    @(negedge P_clk);
    chk("cmd_ready_after_release", {cmd_ready, P_selx}, 2'b10);

    // Recovery after reset
    issue(1'b1, 32'h20, 32'hA5A55A5A, 1, 1'b0, 0);
    issue(1'b0, 32'h20, 32'h0, 0, 1'b0, 1);
    issue(1'b0, 32'h08, 32'h0, 3, 1'b0, 0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
